// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM encoding, default pattern and length check for the serial pattern detector
package seq_det_pkg;
    typedef enum logic {ST_UNCFG, ST_RUN} state_t;
    localparam logic [3:0] PAT_1011 = 4'b1011;
    localparam int PAT_1011_LEN = 4;
    function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
        return (len >= 1) && (len <= max_len);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else q <= clr ? '0 : (inc && q != '1) ? q + W'(1) : q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with Mealy/registered match and saturating count
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    output logic               armed,
    input  logic               x_valid,
    input  logic               x,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_count,
    input  logic               count_clr
);
    state_t state, state_nxt;
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill, len;
    logic [MAX_LEN-1:0] pattern, window, mask;
    logic               overlap, cfg_ok, fill_ok, hit;
    assign cfg_ok  = len_ok(32'(cfg_len), MAX_LEN);
    assign window  = {hist, x};
    // only the low len bits of the window/pattern take part in the compare
    assign mask    = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len);
    assign fill_ok = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len};
    assign hit     = ((window ^ pattern) & mask) == '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_UNCFG;
        else state <= state_nxt;
    always_comb state_nxt = (cfg_load && cfg_ok) ? ST_RUN : state;
    always_comb match = (state == ST_RUN) && x_valid && !cfg_load && fill_ok && hit;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= '0;
            len     <= '0;
            overlap <= 1'b0;
            armed   <= 1'b0;
            cfg_err <= 1'b0;
            match_q <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok;
            match_q <= match;
            if (cfg_load && cfg_ok) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
                armed   <= 1'b1;
            end else if (state == ST_RUN && x_valid) begin
                hist <= window[MAX_LEN-2:0];
                fill <= (match && !overlap) ? '0 : (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
            end
        end
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (count_clr),
        .q     (match_count)
    );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed vectors with hand-computed expectations for seq_detector_param
module tb_seq_detector_param;
    import seq_det_pkg::*;
    logic       clk = 1'b0, reset = 1'b1;
    logic       cfg_load = 1'b0, cfg_overlap = 1'b0, x_valid = 1'b0, x = 1'b0, count_clr = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_err, armed, match, match_q, cfg_err2, armed2, match2, match_q2;
    logic [15:0] match_count;
    logic [1:0]  match_count2;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err), .armed(armed),
        .x_valid(x_valid), .x(x), .match(match), .match_q(match_q),
        .match_count(match_count), .count_clr(count_clr)
    );
    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2), .armed(armed2),
        .x_valid(x_valid), .x(x), .match(match2), .match_q(match_q2),
        .match_count(match_count2), .count_clr(count_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic v, input logic b, input logic em, input string tag);
        @(negedge clk);
        x = b;
        x_valid = v;
        #1 check({tag, " match"}, match, em);
        @(posedge clk);
        #1 check({tag, " match_q"}, match_q, em);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        @(negedge clk);
        cfg_pattern = pat;
        cfg_len = len;
        cfg_overlap = ov;
        cfg_load = 1'b1;
        x_valid = 1'b0;
        @(posedge clk);
        #1 cfg_load = 1'b0;
    endtask

    task automatic clear_count();
        @(negedge clk);
        x_valid = 1'b0;
        count_clr = 1'b1;
        @(posedge clk);
        #1 count_clr = 1'b0;
    endtask

    task automatic stream(input logic [7:0] bits, input logic [7:0] exp, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i], exp[i], tag);
    endtask

    initial begin
        #1;
        check("rst armed", armed, 0);
        check("rst cfg_err", cfg_err, 0);
        check("rst match_q", match_q, 0);
        check("rst count", match_count, 0);
        @(negedge clk) reset = 1'b0;

        load(8'h0B, 4'd0, 1'b1);
        check("len0 cfg_err", cfg_err, 1);
        check("len0 armed", armed, 0);
        @(posedge clk) #1 check("cfg_err pulse", cfg_err, 0);
        load(8'h0B, 4'd9, 1'b1);
        check("len9 cfg_err", cfg_err, 1);
        check("len9 armed", armed, 0);
        stream(8'b1011, 8'b0000, 4, "uncfg");
        check("uncfg count", match_count, 0);

        load(8'hA5, 4'd8, 1'b1);
        check("len8 armed", armed, 1);
        check("len8 cfg_err", cfg_err, 0);
        stream(8'b10100101, 8'b00000001, 8, "a5");
        check("a5 count", match_count, 1);

        clear_count();
        check("clr count", match_count, 0);
        load({4'b0, PAT_1011}, 4'(PAT_1011_LEN), 1'b1);
        stream(8'b1011011, 8'b0001001, 7, "ovl");
        check("ovl count", match_count, 2);

        clear_count();
        load(8'h0B, 4'd4, 1'b0);
        stream(8'b1011011, 8'b0001000, 7, "novl");
        check("novl count", match_count, 1);

        clear_count();
        load(8'h0B, 4'd4, 1'b1);
        send(1, 1, 0, "gap0");
        send(0, 0, 0, "gap1");
        send(0, 1, 0, "gap2");
        send(1, 0, 0, "gap3");
        send(0, 1, 0, "gap4");
        send(1, 1, 0, "gap5");
        send(0, 0, 0, "gap6");
        send(1, 1, 1, "gap7");
        check("gap count", match_count, 1);

        stream(8'b101, 8'b000, 3, "pre");
        load(8'h03, 4'd2, 1'b1);
        stream(8'b111, 8'b011, 3, "reconf");
        check("reconf count", match_count, 3);

        clear_count();
        load(8'h01, 4'd1, 1'b1);
        stream(8'b111111, 8'b111111, 6, "len1");
        check("sat count", match_count2, 3);
        check("wide count", match_count, 6);
        clear_count();
        check("sat clr", match_count2, 0);
        @(negedge clk);
        x = 1'b1;
        x_valid = 1'b1;
        count_clr = 1'b1;
        #1 check("clr+match match", match, 1);
        @(posedge clk);
        #1 count_clr = 1'b0;
        check("clr+match count", match_count, 0);

        load(8'h0B, 4'd4, 1'b1);
        stream(8'b1011, 8'b0001, 4, "prerst");
        check("prerst count", match_count, 1);
        x = 1'b1;
        x_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async armed", armed, 0);
        check("async match", match, 0);
        check("async match_q", match_q, 0);
        check("async count", match_count, 0);
        @(negedge clk) reset = 1'b0;
        send(1, 1, 0, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, run-time programmable serial bit-pattern detector. Successor to the fixed 4-bit "1011" Mealy detector.
- Pattern length (1..MAX_LEN), pattern value and overlap/non-overlap mode are loaded at run time.
- Provides a qualified input stream, Mealy (same-cycle) and registered match outputs, and a saturating match counter.
- Sits on the serial data path between the bit-slicer and the framing/control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 16, width of the match counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- cfg_err  out  1  registered; high for one cycle after a rejected cfg_load.
- armed  out  1  registered; high once a legal configuration is active.
- x_valid  in  1  input bit qualifier.
- x  in  1  serial input bit.
- match  out  1  combinational Mealy output; high in the cycle the final pattern bit is presented.
- match_q  out  1  match registered; one cycle later.
- match_count  out  CNT_W  saturating count of matches.
- count_clr  in  1  synchronous clear of match_count.

Behaviour:
- Reset (asynchronous): state UNCFG; hist=0, fill=0, pattern=0, len=0, overlap=0; armed=0, cfg_err=0, match_q=0, match_count=0.
- FSM has two states:
  - UNCFG: match is forced 0; x is ignored.
  - RUN: detection active.
- Configuration load (cfg_load=1):
  - If 1<=cfg_len<=MAX_LEN: latch the configuration, clear hist and fill, go to RUN, armed=1. Any x_valid in the same cycle is ignored (the new config applies from the next cycle).
  - If cfg_len is illegal: cfg_err pulses for 1 cycle; state and configuration are unchanged.
- History:
  - On x_valid in RUN: hist <= {hist[MAX_LEN-2:0], x}, so hist[0] is the newest bit.
  - fill <= min(fill+1, MAX_LEN).
  - x_valid=0: everything holds.
- Match condition (combinational):
  - match = RUN & x_valid & ~cfg_load & (fill >= len-1) & ({hist[len-2:0], x} == pattern[len-1:0]).
  - len=1 compares x alone.
  - Bits above len-1 are don't-care.
- Non-overlap: on match, fill <= 0; hist is still shifted, but the fill gate blocks reuse of old bits.
- Overlap: fill continues; pattern "11" on input "111" gives 2 matches.
- match_q <= match. Latency is 0 cycles for match and 1 cycle for match_q.
- match_count:
  - Increments on match and saturates at 2^CNT_W-1.
  - count_clr clears it; if count_clr and match occur in the same cycle, the result is 0.
  - cfg_load does not clear it.
- A reset assertion mid-stream drops all partial history immediately; match is 0 while reset is high.

Decomposition:
- Package seq_det_pkg holds:
  - the FSM state encoding (ST_UNCFG, ST_RUN);
  - the default pattern constant PAT_1011 = 4'b1011 with length 4;
  - a function that checks length legality.
- One natural sub-module, sat_counter (parameter W; inputs inc, clr; output q), reused for match_count.
- History, compare and FSM logic stay in the top module.

Test Plan:
- Overlap: load pattern 4'b1011, len=4, overlap=1; drive x=1,0,1,1,0,1,1 with x_valid every cycle -> match on bits 4 and 7; match_q one cycle later each; match_count=2.
- Non-overlap: same stream with overlap=0 -> match on bit 4 only; match_count=1.
- Qualifier gaps: same 1011 with idle x_valid=0 cycles inserted (x toggling garbage while idle) -> exactly one match, coinciding with the 4th valid bit.
- Config:
  - Load cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err pulses each time; armed stays 0; no matches on stream 1011.
  - Then load len=8, pattern 8'hA5 and stream 10100101 -> match on bit 8.
- Reconfigure mid-stream: after input 101, load pattern 2'b11 (len=2), then drive 1,1,1 with overlap=1 -> matches on the 2nd and 3rd bits only; old partial history is not used.
- Saturation/reset:
  - CNT_W=2, six overlapping matches of pattern 1 (len=1) -> count stops at 3; count_clr -> 0.
  - Assert reset asynchronously mid-pattern -> all outputs 0 without waiting for a clock edge; armed=0.
